// File: rtl/counter_seq_ctrl_if.sv
// Bundle between the sequencing controller, its host and the up/down counter.
// slave = controller view, master = host/counter view.
interface counter_seq_ctrl_if #(
  parameter int N      = 3,
  parameter int WRAP_W = 8
);
  logic              start_in;
  logic              stop_in;
  logic              mode_in;
  logic              dir_in;
  logic [N-1:0]      lo_in;
  logic [N-1:0]      hi_in;
  logic [N-1:0]      count_in;
  logic              load_out;
  logic [N-1:0]      d_out;
  logic              up_dn_out;
  logic              en_out;
  logic              busy_out;
  logic              done_out;
  logic              wrap_out;
  logic              err_out;
  logic [WRAP_W-1:0] wraps_out;

  modport slave (
    input  start_in, stop_in, mode_in, dir_in, lo_in, hi_in, count_in,
    output load_out, d_out, up_dn_out, en_out, busy_out, done_out,
           wrap_out, err_out, wraps_out
  );

  modport master (
    output start_in, stop_in, mode_in, dir_in, lo_in, hi_in, count_in,
    input  load_out, d_out, up_dn_out, en_out, busy_out, done_out,
           wrap_out, err_out, wraps_out
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for an N-bit up/down counter: bounded counting between
// latched lo/hi limits, one-shot or auto-reload, with pause/resume/abort,
// done/wrap/err pulses and a saturating reload count.
module counter_seq_ctrl #(
  parameter int N      = 3,
  parameter int WRAP_W = 8
) (
  input  logic               clk,
  input  logic               reset_al_in,
  counter_seq_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [N-1:0]      lo_q, hi_q;
  logic              dir_q, mode_q;
  logic [WRAP_W-1:0] wraps_q;
  logic              busy_q, done_q, wrap_q, err_q;

  logic [N-1:0]      start_val, term_val;
  logic              out_rng, at_term;
  logic              load_c, en_c;

  // Start/terminal values swap with direction; range check uses latched bounds.
  assign start_val = dir_q ? hi_q : lo_q;
  assign term_val  = dir_q ? lo_q : hi_q;
  assign out_rng   = (bus.count_in < lo_q) || (bus.count_in > hi_q);
  assign at_term   = (bus.count_in == term_val);

  // Counter drive: a stop in RUN must freeze the count on the same edge it is seen.
  always_comb begin
    load_c = 1'b0;
    en_c   = 1'b0;
    case (state)
      S_LOAD: load_c = 1'b1;
      S_RUN: begin
        if (!bus.stop_in && !out_rng) begin
          if (at_term) load_c = mode_q;
          else         en_c   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.load_out  = load_c;
  assign bus.en_out    = en_c;
  assign bus.d_out     = start_val;
  assign bus.up_dn_out = dir_q;
  assign bus.busy_out  = busy_q;
  assign bus.done_out  = done_q;
  assign bus.wrap_out  = wrap_q;
  assign bus.err_out   = err_q;
  assign bus.wraps_out = wraps_q;

  // Control FSM with registered status outputs; pulses default low each cycle.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      state   <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      wraps_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!bus.stop_in && bus.start_in) begin
            if (bus.lo_in > bus.hi_in) begin
              err_q <= 1'b1;
            end else begin
              lo_q    <= bus.lo_in;
              hi_q    <= bus.hi_in;
              dir_q   <= bus.dir_in;
              mode_q  <= bus.mode_in;
              wraps_q <= '0;
              busy_q  <= 1'b1;
              state   <= S_LOAD;
            end
          end
        end
        S_LOAD: state <= S_RUN;
        S_RUN: begin
          if (bus.stop_in) begin
            state <= S_PAUSE;
          end else if (out_rng) begin
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else if (at_term) begin
            if (mode_q) begin
              wrap_q <= 1'b1;
              if (~&wraps_q) wraps_q <= wraps_q + WRAP_ONE;
            end else begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= S_DONE;
            end
          end
        end
        S_PAUSE: begin
          if (bus.stop_in) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else if (bus.start_in) begin
            state <= S_RUN;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Sequencing controller that sits directly upstream of the N-bit synchronous up/down counter.
- It drives the counter's load_in, d_in, up/down select and count enable, and takes count_out back as feedback.
- Result: bounded counting between programmable lower/upper limits, either one-shot or auto-reload, with start/stop/pause control, a done pulse, and range-error detection.

Parameters:
N, 3, counter width; all bound/count/data buses are N bits
WRAP_W, 8, width of the saturating reload (wrap) counter

Ports:
clk  input  1  rising-edge clock, shared with the counter
reset_al_in  input  1  asynchronous active-low reset
start_in  input  1  start (in IDLE) or resume (in PAUSE), level-sampled each edge
stop_in  input  1  pause (in RUN) or abort (in PAUSE)
mode_in  input  1  0 = one-shot, 1 = auto-reload; latched at start
dir_in  input  1  0 = up, 1 = down; latched at start
lo_in  input  N  lower bound; latched at start
hi_in  input  N  upper bound; latched at start
count_in  input  N  counter's count_out
load_out  output  1  to counter load_in; load has priority over enable in the counter
d_out  output  N  to counter d_in
up_dn_out  output  1  to counter direction (0 up, 1 down)
en_out  output  1  counter count enable
busy_out  output  1  high in LOAD, RUN, PAUSE
done_out  output  1  one-cycle pulse, one-shot completion
wrap_out  output  1  one-cycle pulse on each auto-reload
err_out  output  1  one-cycle pulse on bad bounds or out-of-range count
wraps_out  output  WRAP_W  saturating count of reloads since last start

Behaviour:
- Reset (async, reset_al_in=0):
  - state=IDLE; latched lo/hi/dir/mode=0; wraps_out=0; err/done/wrap registers=0.
  - Hence load_out=0, en_out=0, d_out=0, up_dn_out=0, busy_out=0.
  - Release is synchronous to the next clk edge.
- Counter contract: on a clk edge with load=1 the counter takes d; else with en=1 it steps ±1; else it holds.
- load_out, en_out and d_out are combinational from registered state, latched config and count_in. All other outputs are registered.
- start = dir ? hi : lo. term = dir ? lo : hi. up_dn_out = latched dir.
- States:
  - IDLE: en=0, load=0.
    - stop_in=1 → stay IDLE.
    - Else start_in=1 and lo_in>hi_in (unsigned) → err_out pulse next cycle, stay IDLE, no latch.
    - Else start_in=1 → latch config, clear wraps_out, go LOAD.
  - LOAD (exactly 1 cycle): load=1, d_out=start, en=0 → RUN. Counter holds the start value at the end of this edge. stop/start are ignored.
  - RUN: en=1 unless one of the following applies (highest priority first):
    1. stop_in=1 → en=0, load=0, go PAUSE. Stop wins over a terminal count.
    2. count_in<lo or count_in>hi → en=0, err_out pulse, go IDLE.
    3. count_in==term and mode=1 → load=1, d_out=start, en=0, stay RUN, wrap_out pulse, wraps_out+1 (saturates at all-ones).
    4. count_in==term and mode=0 → en=0, go DONE.
  - PAUSE: en=0, load=0.
    - stop_in=1 → IDLE (abort, no done).
    - Else start_in=1 → RUN with no reload. The count resumes from its held value.
  - DONE (1 cycle): done_out=1, en=0 → IDLE.
- Boundary conditions:
  - lo==hi: RUN sees term on its first cycle. mode=0 → done 2 cycles after LOAD. mode=1 → reload every RUN cycle, wrap_out held high.
  - Up counting never passes hi; down counting never passes lo. The counter's natural 2^N wrap is never used.
  - lo=0, hi=2^N-1 is legal; the range check never fires.
  - start_in held high in IDLE after DONE restarts immediately (IDLE→LOAD on the next edge).
  - Config inputs changing mid-run have no effect until the next start.
  - Reset asserted mid-operation: outputs go to reset values immediately (asynchronously); the counter also resets.
- Latency:
  - start edge → LOAD → first counter value (start) is visible 2 edges after start is sampled.
  - One count per cycle in RUN.

Test Plan:
- N=3, lo=2, hi=5, dir=0, mode=1, start 1 cycle → count_in 2,3,4,5,2,3,4,5…; wrap_out pulses 1 cycle after each 5; wraps_out=1, 2, …; done_out never asserted.
- lo=1, hi=6, dir=1, mode=0 → count 6,5,4,3,2,1 then hold 1; done_out single pulse; busy_out falls with done; IDLE reached.
- Up run lo=0, hi=7: stop_in at count 4 → count holds 4 for 3 cycles; start_in → 5,6,7 continue; then stop_in in PAUSE for a second run → IDLE, no done_out.
- lo_in=5, hi_in=3, start → err_out single pulse; load_out never asserted; busy_out stays 0.
- RUN with lo=2, hi=5: bench forces count_in=7 (counter load glitch) → err_out pulse, en_out=0, state IDLE. Also lo=hi=3, mode=0 → load 3, done 2 cycles later.
- Reset low mid-RUN at count 4 → load_out/en_out/busy_out/wraps_out=0 immediately. start_in and stop_in asserted the same cycle in IDLE → no start.
